// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder slice.
package serial_adder_pkg;

    localparam int WIDTH_MAX = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    // Bit counter width: ceil(log2(w)), never below 1 so WIDTH=1 still has a flop.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_adder_if.sv
// START/BUSY/DONE bus of the serial adder; OV exists only with SERIAL_ADDER_OVF_EN.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    import serial_adder_pkg::*;

    // START is a request sampled only when BUSY=0 (IDLE or FIN). A, B, CI are
    // captured on that same edge and may change afterwards. BUSY is high for
    // exactly WIDTH cycles, then DONE pulses for one cycle with S/CO valid.
    logic             START;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             CI;
    logic             BUSY;
    logic             DONE;
    logic [WIDTH-1:0] S;
    logic             CO;
    state_t           state;
`ifdef SERIAL_ADDER_OVF_EN
    logic             OV;
`endif

    modport master (
        output START, A, B, CI,
        input  BUSY, DONE, S, CO, state
`ifdef SERIAL_ADDER_OVF_EN
        , input OV
`endif
    );

    modport slave (
        input  START, A, B, CI,
        output BUSY, DONE, S, CO, state
`ifdef SERIAL_ADDER_OVF_EN
        , output OV
`endif
    );

endinterface

// File: rtl/full_adder_cell.sv
// Single-bit full adder; the only arithmetic in the serial adder.
module full_adder_cell (
    input  logic A,
    input  logic B,
    input  logic CI,
    output logic S1,
    output logic CO
);

    assign S1 = A ^ B ^ CI;
    assign CO = (A & B) | (A & CI) | (B & CI);

endmodule

// File: rtl/serial_adder_n.sv
// Bit-serial WIDTH-bit adder, LSB first, one full-adder cell plus a carry flop.
// Optional signed-overflow output OV is enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder_n
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_adder_if.slave  bus
);

    localparam int CNT_W = cnt_width(WIDTH);

    if (WIDTH < 1 || WIDTH > WIDTH_MAX) begin : g_width_check
        $error("serial_adder_n: WIDTH must be within 1..WIDTH_MAX");
    end

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_nxt;
    logic [WIDTH-1:0] s_q;
    logic             co_q;
    logic             carry_ff;
    logic [CNT_W-1:0] cnt;
    logic             last;
    logic             fa_s;
    logic             fa_co;

    full_adder_cell u_fa (
        .A  (a_sh[0]),
        .B  (b_sh[0]),
        .CI (carry_ff),
        .S1 (fa_s),
        .CO (fa_co)
    );

    assign last = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.START) state_nxt = RUN;
            RUN:     if (last)      state_nxt = FIN;
            FIN:     state_nxt = bus.START ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Only WIDTH-1 sum bits need storing: the final bit comes straight from the cell.
    if (WIDTH > 1) begin : g_sum_sh
        logic [WIDTH-2:0] sum_sh;
        assign sum_nxt = {fa_s, sum_sh};
        always_ff @(posedge clk) begin
            if (!rst_n)            sum_sh <= '0;
            else if (state == RUN) sum_sh <= sum_nxt[WIDTH-1:1];
        end
    end else begin : g_sum_bit
        assign sum_nxt = fa_s;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh     <= '0;
            b_sh     <= '0;
            carry_ff <= 1'b0;
            cnt      <= '0;
            s_q      <= '0;
            co_q     <= 1'b0;
        end else begin
            case (state)
                IDLE, FIN: begin
                    if (bus.START) begin
                        a_sh     <= bus.A;
                        b_sh     <= bus.B;
                        carry_ff <= bus.CI;
                        cnt      <= '0;
                    end
                end
                RUN: begin
                    a_sh     <= a_sh >> 1;
                    b_sh     <= b_sh >> 1;
                    carry_ff <= fa_co;
                    cnt      <= cnt + CNT_W'(1);
                    if (last) begin
                        s_q  <= sum_nxt;
                        co_q <= fa_co;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic ov_q;

    // On the last step carry_ff is the carry into the MSB, fa_co the carry out.
    always_ff @(posedge clk) begin
        if (!rst_n)                    ov_q <= 1'b0;
        else if (state == RUN && last) ov_q <= carry_ff ^ fa_co;
    end

    assign bus.OV = ov_q;
`endif

    assign bus.BUSY  = (state == RUN);
    assign bus.DONE  = (state == FIN);
    assign bus.S     = s_q;
    assign bus.CO    = co_q;
    assign bus.state = state;

endmodule

// File: tb/tb_serial_adder_n.sv
// Directed bench for serial_adder_n at WIDTH=1 and WIDTH=8 (OV checks with SERIAL_ADDER_OVF_EN).
`timescale 1ps/1ps
module tb_serial_adder_n;
    import serial_adder_pkg::*;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        logic [7:0] s;
        logic       co;
        logic       ov;
    } vec8_t;

    typedef struct {
        logic       a;
        logic       b;
        logic       ci;
        logic [1:0] cs;
    } vec1_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    always #50 clk = ~clk;

    serial_adder_if #(.WIDTH(1)) bus1 ();
    serial_adder_if #(.WIDTH(8)) bus8 ();

    serial_adder_n #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
    serial_adder_n #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #10;
    endtask

    task automatic wait_done8(inout int k, inout int busy_n);
        while (!bus8.DONE && k < 40) begin
            if (bus8.BUSY) busy_n++;
            tick();
            k++;
        end
    endtask

    task automatic run8(input vec8_t v, input string tag);
        int k;
        int busy_n;
        bus8.START = 1'b1;
        bus8.A     = v.a;
        bus8.B     = v.b;
        bus8.CI    = v.ci;
        tick();
        bus8.START = 1'b0;
        bus8.A     = ~v.a;
        bus8.B     = ~v.b;
        bus8.CI    = ~v.ci;
        k = 0;
        busy_n = 0;
        wait_done8(k, busy_n);
        check($sformatf("%s latency", tag), k, 8);
        check($sformatf("%s busy_cycles", tag), busy_n, 8);
        check($sformatf("%s S", tag), bus8.S, v.s);
        check($sformatf("%s CO", tag), bus8.CO, v.co);
`ifdef SERIAL_ADDER_OVF_EN
        check($sformatf("%s OV", tag), bus8.OV, v.ov);
`endif
        tick();
        check($sformatf("%s done_single", tag), bus8.DONE, 0);
    endtask

    vec8_t vecs8[8];
    vec1_t vecs1[8];

    initial begin
        int k;
        int busy_n;
        int done_n;

        vecs8[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1};
        vecs8[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs8[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs8[3] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs8[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs8[5] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs8[6] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs8[7] = '{8'h7F, 8'h01, 1'b1, 8'h81, 1'b0, 1'b1};

        vecs1[0] = '{1'b0, 1'b0, 1'b0, 2'b00};
        vecs1[1] = '{1'b0, 1'b0, 1'b1, 2'b01};
        vecs1[2] = '{1'b0, 1'b1, 1'b0, 2'b01};
        vecs1[3] = '{1'b0, 1'b1, 1'b1, 2'b10};
        vecs1[4] = '{1'b1, 1'b0, 1'b0, 2'b01};
        vecs1[5] = '{1'b1, 1'b0, 1'b1, 2'b10};
        vecs1[6] = '{1'b1, 1'b1, 1'b0, 2'b10};
        vecs1[7] = '{1'b1, 1'b1, 1'b1, 2'b11};

        // Clock/reset
        rst_n = 1'b0;
        bus1.START = 1'b0; bus1.A = '0; bus1.B = '0; bus1.CI = 1'b0;
        bus8.START = 1'b0; bus8.A = '0; bus8.B = '0; bus8.CI = 1'b0;
        repeat (2) tick();
        check("reset BUSY", bus8.BUSY, 0);
        check("reset DONE", bus8.DONE, 0);
        check("reset S", bus8.S, 0);
        check("reset CO", bus8.CO, 0);
        check("reset state", bus8.state, IDLE);
        check("reset w1 {CO,S}", {bus1.CO, bus1.S}, 0);
        rst_n = 1'b1;
        tick();

        // WIDTH=1 truth table
        for (int i = 0; i < 8; i++) begin
            bus1.START = 1'b1;
            bus1.A     = vecs1[i].a;
            bus1.B     = vecs1[i].b;
            bus1.CI    = vecs1[i].ci;
            tick();
            bus1.START = 1'b0;
            check($sformatf("w1 v%0d busy", i), bus1.BUSY, 1);
            k = 0;
            while (!bus1.DONE && k < 10) begin
                tick();
                k++;
            end
            check($sformatf("w1 v%0d latency", i), k, 1);
            check($sformatf("w1 v%0d {CO,S}", i), {bus1.CO, bus1.S}, vecs1[i].cs);
            tick();
            check($sformatf("w1 v%0d done_single", i), bus1.DONE, 0);
        end

        // WIDTH=8 vector table
        for (int i = 0; i < 8; i++) begin
            run8(vecs8[i], $sformatf("w8 v%0d", i));
        end

        // Chained START held in FIN: FF+01 then FF+FF+1 with no IDLE gap
        bus8.START = 1'b1; bus8.A = 8'hFF; bus8.B = 8'h01; bus8.CI = 1'b0;
        tick();
        bus8.START = 1'b0;
        repeat (7) tick();
        check("chain busy_before_last", bus8.BUSY, 1);
        bus8.START = 1'b1; bus8.A = 8'hFF; bus8.B = 8'hFF; bus8.CI = 1'b1;
        tick();
        check("chain first DONE", bus8.DONE, 1);
        check("chain first S", bus8.S, 8'h00);
        check("chain first CO", bus8.CO, 1);
        tick();
        check("chain no_idle state", bus8.state, RUN);
        check("chain no_idle DONE", bus8.DONE, 0);
        bus8.START = 1'b0;
        k = 0;
        busy_n = 0;
        wait_done8(k, busy_n);
        check("chain second latency", k, 8);
        check("chain second S", bus8.S, 8'hFF);
        check("chain second CO", bus8.CO, 1);
        tick();

        // START pulsed mid-RUN with other operands is ignored
        bus8.START = 1'b1; bus8.A = 8'h5A; bus8.B = 8'h3C; bus8.CI = 1'b0;
        tick();
        bus8.START = 1'b0;
        k = 0;
        busy_n = 0;
        repeat (3) begin
            tick();
            k++;
        end
        bus8.START = 1'b1; bus8.A = 8'h11; bus8.B = 8'h22; bus8.CI = 1'b1;
        tick();
        k++;
        bus8.START = 1'b0;
        wait_done8(k, busy_n);
        check("midrun latency", k, 8);
        check("midrun S", bus8.S, 8'h96);
        check("midrun CO", bus8.CO, 0);
        tick();
        check("midrun no_restart", bus8.state, IDLE);

        // Reset during the 4th RUN cycle
        bus8.START = 1'b1; bus8.A = 8'hFF; bus8.B = 8'h01; bus8.CI = 1'b0;
        tick();
        bus8.START = 1'b0;
        repeat (3) tick();
        check("rstmid busy_before", bus8.BUSY, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rstmid BUSY", bus8.BUSY, 0);
        check("rstmid DONE", bus8.DONE, 0);
        check("rstmid S", bus8.S, 0);
        check("rstmid CO", bus8.CO, 0);
        done_n = 0;
        repeat (10) begin
            tick();
            if (bus8.DONE) done_n++;
        end
        check("rstmid no_done", done_n, 0);
        run8('{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0}, "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
